// File: rtl/decoder_nx2n_seq_if.sv
// decoder_nx2n_seq_if: command handshake and decoded-output bundle for decoder_nx2n_seq.
interface decoder_nx2n_seq_if #(
    parameter int SEL_W = 3,
    parameter int DWELL_W = 8
);
    logic                  i_valid_de;
    logic                  o_ready_de;
    logic [SEL_W-1:0]      i_sel_de;
    logic [1:0]            i_mode_de;
    logic [DWELL_W-1:0]    i_dwell_de;
    logic                  i_en_de;
    logic [2**SEL_W-1:0]   o_dec_de;
    logic                  o_valid_de;
    logic                  o_busy_de;
    logic                  o_wrap_de;

    modport master (
        output i_valid_de, i_sel_de, i_mode_de, i_dwell_de, i_en_de,
        input  o_ready_de, o_dec_de, o_valid_de, o_busy_de, o_wrap_de
    );

    modport slave (
        input  i_valid_de, i_sel_de, i_mode_de, i_dwell_de, i_en_de,
        output o_ready_de, o_dec_de, o_valid_de, o_busy_de, o_wrap_de
    );
endinterface

// File: rtl/decoder_nx2n_seq.sv
// decoder_nx2n_seq: registered N-to-2^N decoder with hold, pulse and timed-scan modes.
module decoder_nx2n_seq #(
    parameter int SEL_W = 3,
    parameter int DWELL_W = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic i_clk_de,
    input logic i_rst_de,
    decoder_nx2n_seq_if.slave bus
);
    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0] INACT = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {IDLE, HOLD, PULSE, SCAN} state_t;

    state_t state, state_n;
    logic [SEL_W-1:0] code, code_n, start, start_n;
    logic [DWELL_W-1:0] dwell, dwell_n, cnt, cnt_n;
    logic armed, armed_n, wrap_n, accept;
    logic [N-1:0] dec;
    logic valid, busy, wrap;

    assign accept = bus.i_valid_de && !busy;

    // armed marks a command accepted while disabled: its first enabled edge only displays it
    always_comb begin
        state_n = state;
        code_n  = code;
        start_n = start;
        dwell_n = dwell;
        cnt_n   = cnt;
        armed_n = armed;
        wrap_n  = 1'b0;
        if (accept) begin
            state_n = bus.i_mode_de == 2'b01 ? PULSE : bus.i_mode_de == 2'b10 ? SCAN : HOLD;
            code_n  = bus.i_sel_de;
            start_n = bus.i_sel_de;
            dwell_n = bus.i_dwell_de;
            cnt_n   = bus.i_dwell_de;
            armed_n = !bus.i_en_de;
        end else if (bus.i_en_de) begin
            if (armed)
                armed_n = 1'b0;
            else if (state == PULSE)
                state_n = IDLE;
            else if (state == SCAN) begin
                if (cnt != '0)
                    cnt_n = cnt - 1'b1;
                else if (code == start - 1'b1)
                    state_n = IDLE;
                else begin
                    code_n = code + 1'b1;
                    cnt_n  = dwell;
                    wrap_n = &code;
                end
            end
        end
    end

    always_ff @(posedge i_clk_de or posedge i_rst_de) begin
        if (i_rst_de) begin
            state <= IDLE;
            code  <= '0;
            start <= '0;
            dwell <= '0;
            cnt   <= '0;
            armed <= 1'b0;
            dec   <= INACT;
            valid <= 1'b0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            code  <= code_n;
            start <= start_n;
            dwell <= dwell_n;
            cnt   <= cnt_n;
            armed <= armed_n;
            dec   <= (bus.i_en_de && state_n != IDLE) ? (N'(1) << code_n) ^ INACT : INACT;
            valid <= bus.i_en_de && state_n != IDLE;
            busy  <= state_n == SCAN;
            wrap  <= wrap_n;
        end
    end

    assign bus.o_dec_de   = dec;
    assign bus.o_valid_de = valid;
    assign bus.o_busy_de  = busy;
    assign bus.o_ready_de = !busy;
    assign bus.o_wrap_de  = wrap;
endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// tb_decoder_nx2n_seq: directed and random stimulus against a counting model of the decoder.
module tb_decoder_nx2n_seq;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decoder_nx2n_seq_if #(.SEL_W(3), .DWELL_W(8)) b0 ();
    decoder_nx2n_seq_if #(.SEL_W(3), .DWELL_W(8)) b1 ();

    assign b1.i_valid_de = b0.i_valid_de;
    assign b1.i_sel_de   = b0.i_sel_de;
    assign b1.i_mode_de  = b0.i_mode_de;
    assign b1.i_dwell_de = b0.i_dwell_de;
    assign b1.i_en_de    = b0.i_en_de;

    decoder_nx2n_seq #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut0 (.i_clk_de(clk), .i_rst_de(rst), .bus(b0));
    decoder_nx2n_seq #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut1 (.i_clk_de(clk), .i_rst_de(rst), .bus(b1));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // model: mode 0 idle, 1 hold, 2 pulse, 3 scan; m_shown counts displayed (enabled) cycles
    int m_mode, m_start, m_dwell, m_shown;
    logic [7:0] m_dec;
    logic m_valid, m_wrap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_start = 0; m_dwell = 0; m_shown = 0;
            m_dec = 8'h00; m_valid = 1'b0; m_wrap = 1'b0;
        end else begin
            int cur;
            if (b0.i_valid_de && m_mode != 3) begin
                m_mode  = (b0.i_mode_de == 2'd1) ? 2 : (b0.i_mode_de == 2'd2) ? 3 : 1;
                m_start = int'(b0.i_sel_de);
                m_dwell = int'(b0.i_dwell_de);
                m_shown = 0;
            end
            m_dec = 8'h00; m_valid = 1'b0; m_wrap = 1'b0;
            if (b0.i_en_de) begin
                if (m_mode == 2 && m_shown == 1) m_mode = 0;
                if (m_mode == 3 && m_shown == N * (m_dwell + 1)) m_mode = 0;
                if (m_mode != 0) begin
                    cur = (m_mode == 3) ? (m_start + m_shown / (m_dwell + 1)) % N : m_start;
                    m_dec = 8'(1) << cur;
                    m_valid = 1'b1;
                    m_wrap = m_mode == 3 && cur == 0 && m_shown > 0 && m_shown % (m_dwell + 1) == 0;
                    m_shown++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("dec", b0.o_dec_de, m_dec);
            chk("dec_active_low", b1.o_dec_de, 8'(~m_dec));
            chk("valid", b0.o_valid_de, m_valid);
            chk("valid_active_low", b1.o_valid_de, m_valid);
            chk("busy", b0.o_busy_de, m_mode == 3);
            chk("ready", b0.o_ready_de, m_mode != 3);
            chk("wrap", b0.o_wrap_de, m_wrap);
        end
    end

    task automatic drive(input logic v, input logic [2:0] s, input logic [1:0] m, input logic [7:0] d, input logic e);
        b0.i_valid_de = v; b0.i_sel_de = s; b0.i_mode_de = m; b0.i_dwell_de = d; b0.i_en_de = e;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_dec"}, b0.o_dec_de, 8'h00);
        chk({name, "_dec_al"}, b1.o_dec_de, 8'hFF);
        chk({name, "_ready"}, b0.o_ready_de, 1);
        chk({name, "_busy"}, b0.o_busy_de, 0);
        chk({name, "_valid"}, b0.o_valid_de, 0);
        chk({name, "_wrap"}, b0.o_wrap_de, 0);
    endtask

    logic [7:0] hold_lit [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] scan_lit [8] = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

    initial begin
        int nvalid;
        drive(0, 0, 0, 0, 1);
        #1 rst = 1'b1;
        #1 chk_reset("reset");
        step;
        rst = 1'b0;
        step;
        for (int k = 0; k < 8; k++) begin
            drive(1, 3'(k), 2'd0, 0, 1);
            step;
            chk("hold_sweep", b0.o_dec_de, hold_lit[k]);
            chk("hold_valid", b0.o_valid_de, 1);
        end
        drive(0, 0, 0, 0, 1);
        step;
        chk("hold_keep", b0.o_dec_de, 8'h80);
        drive(1, 5, 2'd1, 0, 1);
        step;
        chk("pulse_on", b0.o_dec_de, 8'h20);
        drive(0, 0, 0, 0, 1);
        step;
        chk("pulse_off", b0.o_dec_de, 8'h00);
        drive(1, 1, 2'd1, 0, 1);
        step;
        chk("pulse_b2b_1", b0.o_dec_de, 8'h02);
        drive(1, 2, 2'd1, 0, 1);
        step;
        chk("pulse_b2b_2", b0.o_dec_de, 8'h04);
        drive(0, 0, 0, 0, 1);
        step;
        chk("pulse_b2b_off", b0.o_dec_de, 8'h00);
        drive(1, 6, 2'd2, 1, 1);
        step;
        for (int i = 0; i < 16; i++) begin
            chk("scan_code", b0.o_dec_de, scan_lit[i / 2]);
            chk("scan_wrap", b0.o_wrap_de, i == 4);
            chk("scan_ready", b0.o_ready_de, 0);
            if (i == 0) drive(1, 3, 2'd0, 0, 1);
            if (i < 15) step;
        end
        drive(0, 0, 0, 0, 1);
        step;
        chk("scan_end_dec", b0.o_dec_de, 8'h00);
        chk("scan_end_ready", b0.o_ready_de, 1);
        drive(1, 0, 2'd2, 2, 1);
        step;
        nvalid = 1;
        drive(0, 0, 0, 0, 1);
        repeat (9) begin
            step;
            nvalid += int'(b0.o_valid_de);
        end
        chk("freeze_code3", b0.o_dec_de, 8'h08);
        drive(0, 0, 0, 0, 0);
        repeat (4) begin
            step;
            chk("freeze_dec", b0.o_dec_de, 8'h00);
            chk("freeze_valid", b0.o_valid_de, 0);
            chk("freeze_busy", b0.o_busy_de, 1);
        end
        drive(0, 0, 0, 0, 1);
        step;
        chk("resume_a", b0.o_dec_de, 8'h08);
        step;
        chk("resume_b", b0.o_dec_de, 8'h08);
        step;
        chk("resume_next", b0.o_dec_de, 8'h10);
        nvalid += 3;
        for (int j = 0; j < 100 && b0.o_busy_de; j++) begin
            step;
            nvalid += int'(b0.o_valid_de);
        end
        chk("freeze_scan_end", b0.o_busy_de, 0);
        chk("freeze_total", nvalid, 24);
        drive(1, 0, 2'd2, 3, 1);
        step;
        drive(0, 0, 0, 0, 1);
        repeat (8) step;
        chk("midscan_code2", b0.o_dec_de, 8'h04);
        #1 rst = 1'b1;
        #1 chk_reset("midscan_reset");
        step;
        rst = 1'b0;
        drive(1, 7, 2'd0, 0, 1);
        step;
        chk("post_reset_hold", b0.o_dec_de, 8'h80);
        repeat (3000) begin
            drive($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 3)), $urandom_range(0, 9) != 0);
            step;
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        drive(0, 0, 0, 0, 1);
        step;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
